// File: rtl/pmp_mem_guard_pkg.sv
// Shared types for the PMP memory guard: core/bus port structs and the guard state encoding.
package pmp_mem_guard_pkg;

   typedef struct packed {
      logic        mem_valid;
      logic        mem_instr;
      logic [1:0]  mem_mode;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic [31:0] mem_rdata;
      logic        mem_error;
      logic        mem_ready;
   } mem_out_type;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      FAULT,
      DRAIN
   } guard_state_e;

   localparam mem_out_type FaultResp = '{mem_rdata: 32'd0, mem_error: 1'b1, mem_ready: 1'b1};

endpackage

// File: rtl/pmp_mem_guard_buffer.sv
// One-entry holding register for a request (plus its PMP fault bit) that arrives while the guard is busy.
module pmp_mem_guard_buffer
   import pmp_mem_guard_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic       clear,
   input  mem_in_type push_req,
   input  logic       push_err,
   output logic       pend_valid,
   output mem_in_type pend_req,
   output logic       pend_err,
   output logic       overflow
);

   // A push into an occupied entry is dropped and recorded in the sticky overflow flag.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend_valid <= 1'b0;
         pend_req   <= '0;
         pend_err   <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (push && pend_valid) begin
            overflow <= 1'b1;
         end
         if (clear || pop) begin
            pend_valid <= 1'b0;
         end else if (push && !pend_valid) begin
            pend_valid <= 1'b1;
            pend_req   <= push_req;
            pend_err   <= push_err;
         end
      end
   end

endmodule

// File: rtl/pmp_mem_guard.sv
// PMP memory guard: forwards passing requests to the bus one at a time, answers faulting ones locally.
// Define PMP_MEM_GUARD_TIMEOUT_EN to add a bus-response watchdog of TIMEOUT cycles.
module pmp_mem_guard
   import pmp_mem_guard_pkg::*;
`ifdef PMP_MEM_GUARD_TIMEOUT_EN
   #(parameter int unsigned TIMEOUT = 255)
`endif
(
   input  logic        clock,
   input  logic        reset,
   input  logic        pmp_error,
   input  logic        flush,
   input  mem_in_type  core_in,
   output mem_out_type core_out,
   output mem_in_type  bus_in,
   input  mem_out_type bus_out,
   output logic        overflow
);

   guard_state_e state;
   logic         was_idle;
   mem_in_type   bus_q;
   mem_out_type  core_q;

   logic         pend_valid;
   logic         pend_err;
   mem_in_type   pend_req;

   logic         accept;
   logic         direct;
   logic         push;
   logic         pop;
   logic         start;
   logic         sel_err;
   mem_in_type   issue_req;

`ifdef PMP_MEM_GUARD_TIMEOUT_EN
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);
   logic [15:0] tmo_cnt;
`endif

   // The held entry is released only on the second idle cycle, so it behaves like a fresh request.
   assign accept = core_in.mem_valid && !flush;
   assign direct = accept && (state == IDLE) && !pend_valid;
   assign push   = accept && !direct;
   assign pop    = (state == IDLE) && pend_valid && was_idle && !flush;
   assign start  = direct || pop;

   always_comb begin
      issue_req           = direct ? core_in : pend_req;
      issue_req.mem_valid = 1'b1;
      sel_err             = direct ? pmp_error : pend_err;
   end

   pmp_mem_guard_buffer u_buffer (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .clear      (flush),
      .push_req   (core_in),
      .push_err   (pmp_error),
      .pend_valid (pend_valid),
      .pend_req   (pend_req),
      .pend_err   (pend_err),
      .overflow   (overflow)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         was_idle <= 1'b1;
         bus_q    <= '0;
         core_q   <= '0;
`ifdef PMP_MEM_GUARD_TIMEOUT_EN
         tmo_cnt  <= '0;
`endif
      end else begin
         bus_q    <= '0;
         core_q   <= '0;
         was_idle <= (state == IDLE);
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (sel_err) begin
                     core_q <= FaultResp;
                     state  <= FAULT;
                  end else begin
                     bus_q  <= issue_req;
                     state  <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               state <= flush ? DRAIN : WAIT;
`ifdef PMP_MEM_GUARD_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            WAIT: begin
`ifdef PMP_MEM_GUARD_TIMEOUT_EN
               tmo_cnt <= tmo_cnt + 16'd1;
`endif
               // A flush that coincides with the response has nothing left to drain.
               if (flush) begin
                  state <= bus_out.mem_ready ? IDLE : DRAIN;
`ifdef PMP_MEM_GUARD_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
               end else if (bus_out.mem_ready) begin
                  core_q.mem_rdata <= bus_out.mem_rdata;
                  core_q.mem_error <= bus_out.mem_error;
                  core_q.mem_ready <= 1'b1;
                  state            <= IDLE;
               end
`ifdef PMP_MEM_GUARD_TIMEOUT_EN
               else if (tmo_cnt == TimeoutLast) begin
                  core_q  <= FaultResp;
                  state   <= DRAIN;
                  tmo_cnt <= '0;
               end
`endif
            end
            FAULT: begin
               state <= IDLE;
            end
            DRAIN: begin
`ifdef PMP_MEM_GUARD_TIMEOUT_EN
               tmo_cnt <= tmo_cnt + 16'd1;
`endif
               if (bus_out.mem_ready) begin
                  state <= IDLE;
               end
`ifdef PMP_MEM_GUARD_TIMEOUT_EN
               else if (tmo_cnt == TimeoutLast) begin
                  state <= IDLE;
               end
`endif
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // A flush in the FAULT cycle cancels the locally generated error response.
   always_comb begin
      core_out = core_q;
      if ((state == FAULT) && flush) begin
         core_out.mem_error = 1'b0;
         core_out.mem_ready = 1'b0;
      end
   end

   assign bus_in = bus_q;

endmodule

// File: tb/tb_pmp_mem_guard.sv
// Scoreboard bench for pmp_mem_guard: directed requests push expected bus/core events, a monitor checks them.
module tb_pmp_mem_guard;
   import pmp_mem_guard_pkg::*;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } core_exp_t;

   typedef struct packed {
      mem_in_type  req;
      int          cyc;
   } bus_exp_t;

   logic        clock;
   logic        reset;
   logic        pmp_error;
   logic        flush;
   mem_in_type  core_in;
   mem_out_type core_out;
   mem_in_type  bus_in;
   mem_out_type bus_out;
   logic        overflow;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   core_exp_t core_q[$];
   bus_exp_t  bus_q[$];

`ifdef PMP_MEM_GUARD_TIMEOUT_EN
   pmp_mem_guard #(.TIMEOUT(4)) dut (
`else
   pmp_mem_guard dut (
`endif
      .clock     (clock),
      .reset     (reset),
      .pmp_error (pmp_error),
      .flush     (flush),
      .core_in   (core_in),
      .core_out  (core_out),
      .bus_in    (bus_in),
      .bus_out   (bus_out),
      .overflow  (overflow)
   );

   // Free-running clock and a cycle counter used to timestamp expectations.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   function automatic mem_in_type mkReq(input logic [31:0] addr, input logic [1:0] mode,
                                        input logic instr, input logic [3:0] wstrb,
                                        input logic [31:0] wdata);
      mem_in_type r;
      r.mem_valid = 1'b1;
      r.mem_instr = instr;
      r.mem_mode  = mode;
      r.mem_addr  = addr;
      r.mem_wdata = wdata;
      r.mem_wstrb = wstrb;
      return r;
   endfunction

   task automatic expectCore(input logic [31:0] rdata, input logic err, input int at);
      core_exp_t e;
      e.rdata = rdata;
      e.err   = err;
      e.cyc   = at;
      core_q.push_back(e);
   endtask

   task automatic expectBus(input mem_in_type r, input int at);
      bus_exp_t e;
      e.req = r;
      e.cyc = at;
      bus_q.push_back(e);
   endtask

   // Drives a one-cycle request pulse (optionally with flush) and returns one cycle later.
   task automatic applyStimulus(input mem_in_type r, input logic err, input logic fl);
      core_in   = r;
      pmp_error = err;
      flush     = fl;
      step(1);
      core_in   = '0;
      pmp_error = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic busRespond(input logic [31:0] rdata, input logic err);
      bus_out.mem_rdata = rdata;
      bus_out.mem_error = err;
      bus_out.mem_ready = 1'b1;
      step(1);
      bus_out = '0;
   endtask

   task automatic pulseFlush();
      flush = 1'b1;
      step(1);
      flush = 1'b0;
   endtask

   // Monitor: every presented response or bus request must match the head of its queue.
   always @(negedge clock) begin
      if (reset) begin
         if (core_out.mem_ready) begin
            if (core_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL core_unexpected actual=rdata %0h err %0b required=no response (cycle %0d)",
                        core_out.mem_rdata, core_out.mem_error, cyc);
            end else begin
               core_exp_t e;
               e = core_q.pop_front();
               checkOutput("core_rdata", 128'(core_out.mem_rdata), 128'(e.rdata));
               checkOutput("core_error", 128'(core_out.mem_error), 128'(e.err));
               checkOutput("core_cycle", 128'(cyc), 128'(e.cyc));
            end
         end else begin
            checkOutput("core_idle_error", 128'(core_out.mem_error), 128'(0));
         end
         if (bus_in.mem_valid) begin
            if (bus_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL bus_unexpected actual=addr %0h required=no request (cycle %0d)",
                        bus_in.mem_addr, cyc);
            end else begin
               bus_exp_t b;
               b = bus_q.pop_front();
               checkOutput("bus_req", 128'(bus_in), 128'(b.req));
               checkOutput("bus_cycle", 128'(cyc), 128'(b.cyc));
            end
         end else begin
            checkOutput("bus_idle_fields", 128'(bus_in), 128'(0));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=still running required=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      mem_in_type r;
      mem_in_type r2;

      core_in   = '0;
      pmp_error = 1'b0;
      flush     = 1'b0;
      bus_out   = '0;
      reset     = 1'b1;
      #1 reset  = 1'b0;
      #1;
      checkOutput("reset_core_out", 128'(core_out), 128'(0));
      checkOutput("reset_bus_in", 128'(bus_in), 128'(0));
      checkOutput("reset_overflow", 128'(overflow), 128'(0));
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      step(1);

      $display("[TB] fault path");
      n = cyc;
      expectCore(32'h0, 1'b1, n + 1);
      applyStimulus(mkReq(32'h8000_0000, 2'd0, 1'b0, 4'h0, 32'h0), 1'b1, 1'b0);
      step(3);

      $display("[TB] pass path");
      n = cyc;
      r = mkReq(32'h0000_1000, 2'd0, 1'b0, 4'h0, 32'h0);
      expectBus(r, n + 1);
      expectCore(32'hDEAD_BEEF, 1'b0, n + 5);
      applyStimulus(r, 1'b0, 1'b0);
      step(3);
      busRespond(32'hDEAD_BEEF, 1'b0);
      step(3);

      $display("[TB] buffering and overflow");
      n = cyc;
      r = mkReq(32'h0000_2000, 2'd3, 1'b1, 4'h0, 32'h0);
      expectBus(r, n + 1);
      expectCore(32'h1111_1111, 1'b0, n + 6);
      expectCore(32'h0, 1'b1, n + 8);
      applyStimulus(r, 1'b0, 1'b0);
      step(2);
      applyStimulus(mkReq(32'h0000_3000, 2'd0, 1'b0, 4'hF, 32'h1234_5678), 1'b1, 1'b0);
      checkOutput("overflow_before", 128'(overflow), 128'(0));
      applyStimulus(mkReq(32'h0000_4000, 2'd0, 1'b0, 4'h1, 32'hAAAA_5555), 1'b0, 1'b0);
      checkOutput("overflow_set", 128'(overflow), 128'(1));
      busRespond(32'h1111_1111, 1'b0);
      step(4);
      checkOutput("overflow_sticky", 128'(overflow), 128'(1));

      $display("[TB] flush in wait");
      n = cyc;
      r = mkReq(32'h0000_5000, 2'd0, 1'b0, 4'h3, 32'h0000_BEEF);
      expectBus(r, n + 1);
      applyStimulus(r, 1'b0, 1'b0);
      step(2);
      pulseFlush();
      step(1);
      busRespond(32'hBAD0_BAD0, 1'b0);
      step(1);
      n = cyc;
      r = mkReq(32'h0000_6000, 2'd0, 1'b1, 4'h0, 32'h0);
      expectBus(r, n + 1);
      expectCore(32'hCAFE_F00D, 1'b0, n + 4);
      applyStimulus(r, 1'b0, 1'b0);
      step(2);
      busRespond(32'hCAFE_F00D, 1'b0);
      step(2);

      $display("[TB] flush in fault and flush with request");
      applyStimulus(mkReq(32'h8000_0100, 2'd0, 1'b0, 4'h0, 32'h0), 1'b1, 1'b0);
      pulseFlush();
      step(2);
      applyStimulus(mkReq(32'h8000_0200, 2'd0, 1'b0, 4'h0, 32'h0), 1'b1, 1'b1);
      step(3);
      n = cyc;
      expectCore(32'h0, 1'b1, n + 1);
      applyStimulus(mkReq(32'h0000_9000, 2'd0, 1'b0, 4'h0, 32'h0), 1'b1, 1'b0);
      step(2);

      $display("[TB] async reset mid-wait");
      n = cyc;
      r = mkReq(32'h0000_7000, 2'd3, 1'b0, 4'h0, 32'h0);
      expectBus(r, n + 1);
      applyStimulus(r, 1'b0, 1'b0);
      step(2);
      #3 reset = 1'b0;
      #1;
      checkOutput("async_core_out", 128'(core_out), 128'(0));
      checkOutput("async_bus_in", 128'(bus_in), 128'(0));
      checkOutput("async_overflow", 128'(overflow), 128'(0));
      @(posedge clock);
      #1 reset = 1'b1;
      busRespond(32'h5555_5555, 1'b0);
      step(2);
      n = cyc;
      r2 = mkReq(32'h0000_8000, 2'd3, 1'b1, 4'h0, 32'h0);
      expectBus(r2, n + 1);
      expectCore(32'h0BAD_F00D, 1'b1, n + 3);
      applyStimulus(r2, 1'b0, 1'b0);
      step(1);
      busRespond(32'h0BAD_F00D, 1'b1);
      step(2);

`ifdef PMP_MEM_GUARD_TIMEOUT_EN
      $display("[TB] bus timeout");
      n = cyc;
      r = mkReq(32'h0000_A000, 2'd0, 1'b0, 4'h0, 32'h0);
      expectBus(r, n + 1);
      expectCore(32'h0, 1'b1, n + 6);
      applyStimulus(r, 1'b0, 1'b0);
      step(6);
      busRespond(32'h7777_7777, 1'b0);
      step(4);
      n = cyc;
      r = mkReq(32'h0000_B000, 2'd0, 1'b0, 4'h0, 32'h0);
      expectBus(r, n + 1);
      expectCore(32'h2222_2222, 1'b0, n + 3);
      applyStimulus(r, 1'b0, 1'b0);
      step(1);
      busRespond(32'h2222_2222, 1'b0);
      step(2);
`endif

      step(5);
      checkOutput("core_queue_drained", 128'(core_q.size()), 128'(0));
      checkOutput("bus_queue_drained", 128'(bus_q.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
